// File: rtl/hc595_rx.sv
// Receive side of the 74HC595 display bus: synchronizes DS/SH_CP/ST_CP, rebuilds the
// 16-bit frame and publishes seg/sel the way the 595 storage register would.
module hc595_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_BITS  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        DS,
   input  logic        SH_CP,
   input  logic        ST_CP,
   output logic [7:0]  seg,
   output logic [7:0]  sel,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   localparam int unsigned SHREG_W = 16;
   localparam int unsigned BCNT_W  = 6;
   localparam int unsigned BCNT_MAX = (1 << BCNT_W) - 1;

   // Identical chains so DS stays aligned with the clock wires it is sampled against.
   logic [SYNC_STAGES-1:0] ds_sync;
   logic [SYNC_STAGES-1:0] sh_sync;
   logic [SYNC_STAGES-1:0] st_sync;
   logic                   sh_prev;
   logic                   st_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ds_sync <= '0;
         sh_sync <= '0;
         st_sync <= '0;
         sh_prev <= 1'b0;
         st_prev <= 1'b0;
      end else begin
         ds_sync <= {ds_sync[SYNC_STAGES-2:0], DS};
         sh_sync <= {sh_sync[SYNC_STAGES-2:0], SH_CP};
         st_sync <= {st_sync[SYNC_STAGES-2:0], ST_CP};
         sh_prev <= sh_sync[SYNC_STAGES-1];
         st_prev <= st_sync[SYNC_STAGES-1];
      end
   end

   logic ds_s_c;
   logic sh_fire_c;
   logic st_fire_c;

   // prev tracks regardless of en, so enabling mid-pulse never fabricates an edge.
   assign ds_s_c    = ds_sync[SYNC_STAGES-1];
   assign sh_fire_c = en & sh_sync[SYNC_STAGES-1] & ~sh_prev;
   assign st_fire_c = en & st_sync[SYNC_STAGES-1] & ~st_prev;

   logic [SHREG_W-1:0] shreg;
   logic [BCNT_W-1:0]  bit_cnt;

   logic [SHREG_W-1:0] shreg_n;
   logic [BCNT_W-1:0]  bit_cnt_n;
   logic [7:0]         seg_n;
   logic [7:0]         sel_n;
   logic               frame_valid_n;
   logic               frame_err_n;
   logic [15:0]        frame_cnt_n;

   // Latch reads the pre-shift register, so tied SH_CP/ST_CP behaves like the real part.
   always_comb begin
      shreg_n       = shreg;
      bit_cnt_n     = bit_cnt;
      seg_n         = seg;
      sel_n         = sel;
      frame_valid_n = 1'b0;
      frame_err_n   = frame_err;
      frame_cnt_n   = frame_cnt;

      if (sh_fire_c) begin
         shreg_n = {shreg[SHREG_W-2:0], ds_s_c};
         if (32'(bit_cnt) != BCNT_MAX) begin
            bit_cnt_n = bit_cnt + BCNT_W'(1);
         end
      end

      if (st_fire_c) begin
         seg_n         = shreg[15:8];
         sel_n         = shreg[7:0];
         frame_valid_n = 1'b1;
         frame_err_n   = (32'(bit_cnt) < FRAME_BITS);
         frame_cnt_n   = frame_cnt + 16'd1;
         bit_cnt_n     = sh_fire_c ? BCNT_W'(1) : BCNT_W'(0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg       <= '0;
         bit_cnt     <= '0;
         seg         <= '0;
         sel         <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         shreg       <= shreg_n;
         bit_cnt     <= bit_cnt_n;
         seg         <= seg_n;
         sel         <= sel_n;
         frame_valid <= frame_valid_n;
         frame_err   <= frame_err_n;
         frame_cnt   <= frame_cnt_n;
      end
   end

endmodule

// File: tb/tb_hc595_rx.sv
// Scoreboard bench for hc595_rx: a frame-level model queues expected latches and a
// monitor compares every frame_valid pulse; a second instance checks deeper sync latency.
module tb_hc595_rx;

   typedef struct packed {
      logic [7:0]  seg;
      logic [7:0]  sel;
      logic        err;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        DS;
   logic        SH_CP;
   logic        ST_CP;
   logic [7:0]  seg, sel, seg3, sel3;
   logic        frame_valid, frame_err, frame_valid3, frame_err3;
   logic [15:0] frame_cnt, frame_cnt3;

   hc595_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
      .clk(clk), .rst(rst), .en(en), .DS(DS), .SH_CP(SH_CP), .ST_CP(ST_CP),
      .seg(seg), .sel(sel), .frame_valid(frame_valid), .frame_err(frame_err),
      .frame_cnt(frame_cnt)
   );

   hc595_rx #(.SYNC_STAGES(3), .FRAME_BITS(16)) dut3 (
      .clk(clk), .rst(rst), .en(en), .DS(DS), .SH_CP(SH_CP), .ST_CP(ST_CP),
      .seg(seg3), .sel(sel3), .frame_valid(frame_valid3), .frame_err(frame_err3),
      .frame_cnt(frame_cnt3)
   );

   always #5 clk = ~clk;

   int          tests  = 0;
   int          fails  = 0;
   int          pulses = 0;
   exp_t        q[$];
   logic [15:0] m_shreg;
   int          m_bits;
   logic [15:0] m_cnt;
   logic        fv_prev = 1'b0;

   // Monitor: every frame_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && frame_valid) begin
         pulses++;
         tests++;
         if (fv_prev !== 1'b0) begin
            fails++;
            $display("FAIL pulse_width: frame_valid high on consecutive cycles");
         end
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: seg=%h sel=%h err=%b cnt=%h, none expected",
                     seg, sel, frame_err, frame_cnt);
         end else begin
            e = q.pop_front();
            if (seg !== e.seg || sel !== e.sel || frame_err !== e.err || frame_cnt !== e.cnt) begin
               fails++;
               $display("FAIL frame: got seg=%h sel=%h err=%b cnt=%h, want seg=%h sel=%h err=%b cnt=%h",
                        seg, sel, frame_err, frame_cnt, e.seg, e.sel, e.err, e.cnt);
            end
         end
      end
      fv_prev <= frame_valid;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bit(input logic b);
      DS = b;
      idle(2);
      SH_CP = 1'b1;
      if (en) begin
         m_shreg = {m_shreg[14:0], b};
         m_bits++;
      end
      idle(3);
      SH_CP = 1'b0;
      idle(2);
   endtask

   task automatic send(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
   endtask

   task automatic push_latch();
      exp_t e;
      e.seg = m_shreg[15:8];
      e.sel = m_shreg[7:0];
      e.err = (m_bits < 16);
      m_cnt = m_cnt + 16'd1;
      e.cnt = m_cnt;
      q.push_back(e);
      m_bits = 0;
   endtask

   task automatic latch();
      ST_CP = 1'b1;
      if (en) push_latch();
      idle(3);
      ST_CP = 1'b0;
      idle(5);
   endtask

   task automatic test_reset();
      tests++;
      if ({seg, sel, frame_valid, frame_err, frame_cnt} !== 34'd0) begin
         fails++;
         $display("FAIL reset_init: got seg=%h sel=%h fv=%b err=%b cnt=%h, want all 0",
                  seg, sel, frame_valid, frame_err, frame_cnt);
      end
      rst = 1'b0;
      idle(2);
      send(32'h5, 4);
      DS = 1'b1;
      idle(2);
      SH_CP = 1'b1;
      idle(1);
      rst = 1'b1;
      idle(1);
      SH_CP = 1'b0;
      idle(2);
      tests++;
      if ({seg, sel, frame_valid, frame_err, frame_cnt} !== 34'd0) begin
         fails++;
         $display("FAIL reset_mid: got seg=%h sel=%h fv=%b err=%b cnt=%h, want all 0",
                  seg, sel, frame_valid, frame_err, frame_cnt);
      end
      m_shreg = '0;
      m_bits  = 0;
      m_cnt   = '0;
      rst = 1'b0;
      idle(2);
      send(32'hC3, 8);
      latch();
      tests++;
      if (seg !== 8'h00 || sel !== 8'hC3 || frame_err !== 1'b1 || frame_cnt !== 16'd1) begin
         fails++;
         $display("FAIL reset_first_latch: got seg=%h sel=%h err=%b cnt=%h, want 00 c3 1 0001",
                  seg, sel, frame_err, frame_cnt);
      end
   endtask

   task automatic test_loopback();
      int p0 = pulses;
      send(32'h1A53C, 17);
      latch();
      tests++;
      if (seg !== 8'hA5 || sel !== 8'h3C || frame_err !== 1'b0 || frame_cnt !== 16'd2) begin
         fails++;
         $display("FAIL loopback: got seg=%h sel=%h err=%b cnt=%h, want a5 3c 0 0002",
                  seg, sel, frame_err, frame_cnt);
      end
      tests++;
      if (pulses - p0 !== 1) begin
         fails++;
         $display("FAIL loopback_pulses: got %0d pulses, want 1", pulses - p0);
      end
   endtask

   task automatic test_short_frame();
      send(32'hABC, 12);
      latch();
      tests++;
      if (seg !== 8'hCA || sel !== 8'hBC || frame_err !== 1'b1 || frame_cnt !== 16'd3) begin
         fails++;
         $display("FAIL short_frame: got seg=%h sel=%h err=%b cnt=%h, want ca bc 1 0003",
                  seg, sel, frame_err, frame_cnt);
      end
   endtask

   task automatic test_tied_clocks();
      send(32'h1234, 16);
      DS = 1'b1;
      idle(2);
      SH_CP = 1'b1;
      ST_CP = 1'b1;
      push_latch();
      m_shreg = {m_shreg[14:0], 1'b1};
      m_bits  = 1;
      idle(3);
      SH_CP = 1'b0;
      ST_CP = 1'b0;
      idle(5);
      tests++;
      if (seg !== 8'h12 || sel !== 8'h34 || frame_err !== 1'b0 || frame_cnt !== 16'd4) begin
         fails++;
         $display("FAIL tied_latch: got seg=%h sel=%h err=%b cnt=%h, want 12 34 0 0004",
                  seg, sel, frame_err, frame_cnt);
      end
      send(32'h5A5A, 15);
      latch();
      tests++;
      if (seg !== 8'hDA || sel !== 8'h5A || frame_err !== 1'b0 || frame_cnt !== 16'd5) begin
         fails++;
         $display("FAIL tied_next_frame: got seg=%h sel=%h err=%b cnt=%h, want da 5a 0 0005",
                  seg, sel, frame_err, frame_cnt);
      end
   endtask

   task automatic test_en_gating();
      int p0 = pulses;
      en = 1'b0;
      send(32'hFFFF, 16);
      latch();
      tests++;
      if (pulses !== p0 || seg !== 8'hDA || sel !== 8'h5A || frame_cnt !== 16'd5) begin
         fails++;
         $display("FAIL en_off: got pulses+%0d seg=%h sel=%h cnt=%h, want +0 da 5a 0005",
                  pulses - p0, seg, sel, frame_cnt);
      end
      DS = 1'b1;
      SH_CP = 1'b1;
      idle(4);
      en = 1'b1;
      idle(4);
      SH_CP = 1'b0;
      idle(2);
      latch();
      tests++;
      if (seg !== 8'hDA || sel !== 8'h5A || frame_err !== 1'b1 || frame_cnt !== 16'd6) begin
         fails++;
         $display("FAIL en_raise_no_shift: got seg=%h sel=%h err=%b cnt=%h, want da 5a 1 0006",
                  seg, sel, frame_err, frame_cnt);
      end
   endtask

   task automatic test_wrap();
      force dut.frame_cnt = 16'hFFFF;
      idle(1);
      release dut.frame_cnt;
      idle(1);
      tests++;
      if (frame_cnt !== 16'hFFFF) begin
         fails++;
         $display("FAIL wrap_preload: got cnt=%h, want ffff", frame_cnt);
      end
      m_cnt = 16'hFFFF;
      latch();
      tests++;
      if (frame_cnt !== 16'h0000) begin
         fails++;
         $display("FAIL wrap: got cnt=%h, want 0000", frame_cnt);
      end
   endtask

   task automatic test_latency();
      int          first2 = 0;
      int          first3 = 0;
      logic [15:0] snap;
      send(32'h7E81, 16);
      snap  = m_shreg;
      ST_CP = 1'b1;
      push_latch();
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (frame_valid && first2 == 0) first2 = k;
         if (frame_valid3 && first3 == 0) first3 = k;
      end
      ST_CP = 1'b0;
      idle(5);
      tests++;
      if (first2 !== 3) begin
         fails++;
         $display("FAIL latency_sync2: frame_valid on edge %0d, want 3", first2);
      end
      tests++;
      if (first3 !== 4) begin
         fails++;
         $display("FAIL latency_sync3: frame_valid on edge %0d, want 4", first3);
      end
      tests++;
      if (seg3 !== snap[15:8] || sel3 !== snap[7:0] || frame_err3 !== 1'b0 || frame_cnt3 !== 16'd8) begin
         fails++;
         $display("FAIL sync3_frame: got seg=%h sel=%h err=%b cnt=%h, want %h %h 0 0008",
                  seg3, sel3, frame_err3, frame_cnt3, snap[15:8], snap[7:0]);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; DS = 1'b0; SH_CP = 1'b0; ST_CP = 1'b0;
      m_shreg = '0; m_bits = 0; m_cnt = '0;
      idle(3);
      test_reset();
      test_loopback();
      test_short_frame();
      test_tied_clocks();
      test_en_gating();
      test_wrap();
      test_latency();
      idle(4);
      tests++;
      if (q.size() !== 0) begin
         fails++;
         $display("FAIL missing_pulses: %0d expected frames never seen, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
